// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel/line counters with registered sync, blank and
// frame-tick strobes, all decoded from the next counter values so they stay aligned.
module vga_timing_gen #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33
) (
    input  logic       VGA_Clk,
    input  logic       Reset_h,
    input  logic       pix_ce,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       blank,
    output logic       frame_tick
);

    localparam int unsigned CNT_W = 10;
    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

    // Decode bounds kept 32-bit so a sync ending exactly at 1024 cannot wrap.
    localparam int unsigned H_SYNC_START = H_VISIBLE + H_FRONT;
    localparam int unsigned H_SYNC_END   = H_VISIBLE + H_FRONT + H_SYNC;
    localparam int unsigned V_SYNC_START = V_VISIBLE + V_FRONT;
    localparam int unsigned V_SYNC_END   = V_VISIBLE + V_FRONT + V_SYNC;
    localparam int unsigned H_TICK       = H_VISIBLE - 1;
    localparam int unsigned V_TICK       = V_VISIBLE - 1;

    logic [CNT_W-1:0] hc_q, hc_d;
    logic [CNT_W-1:0] vc_q, vc_d;
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;
    logic             blank_q, blank_d;
    logic             tick_q, tick_d;

    // Next counter values and strobes decoded from them; everything holds when pix_ce is low.
    always_comb begin
        hc_d    = hc_q;
        vc_d    = vc_q;
        hs_d    = hs_q;
        vs_d    = vs_q;
        blank_d = blank_q;
        tick_d  = tick_q;
        if (pix_ce) begin
            if (hc_q == H_LAST) begin
                hc_d = '0;
                vc_d = (vc_q == V_LAST) ? '0 : vc_q + CNT_W'(1);
            end else begin
                hc_d = hc_q + CNT_W'(1);
            end
            hs_d    = !((32'(hc_d) >= H_SYNC_START) && (32'(hc_d) < H_SYNC_END));
            vs_d    = !((32'(vc_d) >= V_SYNC_START) && (32'(vc_d) < V_SYNC_END));
            blank_d = (32'(hc_d) < H_VISIBLE) && (32'(vc_d) < V_VISIBLE);
            tick_d  = (32'(hc_d) == H_TICK) && (32'(vc_d) == V_TICK);
        end
    end

    always_ff @(posedge VGA_Clk) begin
        if (Reset_h) begin
            hc_q    <= '0;
            vc_q    <= '0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            blank_q <= 1'b1;
            tick_q  <= 1'b0;
        end else begin
            hc_q    <= hc_d;
            vc_q    <= vc_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            blank_q <= blank_d;
            tick_q  <= tick_d;
        end
    end

    assign DrawX      = hc_q;
    assign DrawY      = vc_q;
    assign VGA_HS     = hs_q;
    assign VGA_VS     = vs_q;
    assign blank      = blank_q;
    assign frame_tick = tick_q;

endmodule
